// File: rtl/hc595_pkg.sv
// hc595_pkg: shared constants, control-state type and state-decode helper
// for the SN74HC595 three-wire link receiver (hc595_serial_rx).
//
// Contents:
//   HC595_WIDTH_DEFAULT  default frame length in bits
//   HC595_CNT_MAX        saturation value of the shift counter
//   hc595_rx_state_t     control state (IDLE, SHIFTING, FULL, OVERRUN)
//   hc595_state_of()     maps a shift count to its control state
package hc595_pkg;

    localparam int          HC595_WIDTH_DEFAULT = 8;
    localparam logic [7:0]  HC595_CNT_MAX       = 8'd255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        FULL     = 2'd2,
        OVERRUN  = 2'd3
    } hc595_rx_state_t;

    // State is a pure function of the shift count, so the FSM can never
    // disagree with o_shift_cnt.
    function automatic hc595_rx_state_t hc595_state_of(input logic [7:0] cnt,
                                                       input logic [7:0] width);
        hc595_rx_state_t st;
        if (cnt == 8'd0) begin
            st = IDLE;
        end else if (cnt < width) begin
            st = SHIFTING;
        end else if (cnt == width) begin
            st = FULL;
        end else begin
            st = OVERRUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/hc595_rx_cond.sv
// hc595_rx_cond: conditions one asynchronous wire of the HC595 link.
// A SYNC_STAGES-deep synchronizer is optionally followed by a glitch filter
// (compiled in with HC595_RX_GLITCH_FILTER_EN, needing FILT_CYCLES equal
// samples to change), then a registered rising-edge detector.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   din    raw pin level, asynchronous to clk
//   level  conditioned level, delayed one cycle so it lines up with rise
//   rise   one-cycle pulse on a conditioned rising edge
module hc595_rx_cond
    import hc595_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    if (SYNC_STAGES < 2 || FILT_CYCLES < 1) begin : g_param_err
        $error("hc595_rx_cond: SYNC_STAGES must be >= 2 and FILT_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   cond_s;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    // Synchronizer shift chain: next value of every stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef HC595_RX_GLITCH_FILTER_EN
    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic          filt_q, filt_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    // Glitch filter: count consecutive samples that disagree with the
    // filtered level; flip only on the FILT_CYCLES-th one.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == CW'(FILT_CYCLES - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + CW'(1);
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // Glitch filter state flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cond_s = filt_q;
`else
    assign cond_s = sync_q[SYNC_STAGES-1];
`endif

    // Edge detector: rise is registered, and level is the matching delayed
    // copy, so data sampled on rise is the value present at the pin edge.
    always_comb begin
        level_d = cond_s;
        rise_d  = cond_s & ~level_q;
    end

    // Edge detector flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/hc595_serial_rx.sv
// hc595_serial_rx: receiver for the three-wire SN74HC595 link. Conditions
// the data, shift-clock and storage-clock wires, deserializes frames and
// presents the latched frame with a one-cycle valid strobe.
// Optional glitch filter: define HC595_RX_GLITCH_FILTER_EN.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   SN74HC595_data            serial data pin
//   SN74HC595_data_clk        shift clock pin (rising edge shifts)
//   SN74HC595_refresh_clk     storage clock pin (rising edge latches)
//   o_buf                     latched frame, MSB = first bit shifted in
//   o_valid                   one-cycle pulse when o_buf updates
//   o_frame_err               pulse with o_valid when count != WIDTH
//   o_shift_cnt               bits shifted since last latch, saturating
//   o_qh                      cascade output (shift register MSB)
module hc595_serial_rx
    import hc595_pkg::*;
#(
    parameter int WIDTH       = HC595_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SN74HC595_data,
    input  logic             SN74HC595_data_clk,
    input  logic             SN74HC595_refresh_clk,
    output logic [WIDTH-1:0] o_buf,
    output logic             o_valid,
    output logic             o_frame_err,
    output logic [7:0]       o_shift_cnt,
    output logic             o_qh
);

    localparam logic [7:0] WIDTH_CNT = 8'(WIDTH);

    logic data_s, shift_p_s, latch_p_s;
    logic data_rise_unused_s, shift_level_unused_s, latch_level_unused_s;

    hc595_rx_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond_data (
        .clk(clk), .rst(rst), .din(SN74HC595_data),
        .level(data_s), .rise(data_rise_unused_s)
    );

    hc595_rx_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond_shift (
        .clk(clk), .rst(rst), .din(SN74HC595_data_clk),
        .level(shift_level_unused_s), .rise(shift_p_s)
    );

    hc595_rx_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_cond_latch (
        .clk(clk), .rst(rst), .din(SN74HC595_refresh_clk),
        .level(latch_level_unused_s), .rise(latch_p_s)
    );

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;
    hc595_rx_state_t  state_q, state_d;

    // Frame datapath and control. On a simultaneous shift and latch the
    // storage register takes the pre-shift contents and the error check
    // uses the pre-increment state, like the real part.
    always_comb begin
        sr_d    = sr_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        if (latch_p_s) begin
            buf_d   = sr_q;
            valid_d = 1'b1;
            err_d   = (state_q != FULL);
        end else begin
            buf_d   = buf_q;
        end

        if (shift_p_s) begin
            sr_d = {sr_q[WIDTH-2:0], data_s};
            if (latch_p_s) begin
                cnt_d = 8'd1;
            end else if (cnt_q != HC595_CNT_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (latch_p_s) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q;
        end

        state_d = hc595_state_of(cnt_d, WIDTH_CNT);
    end

    // Frame and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            state_q <= IDLE;
        end else begin
            sr_q    <= sr_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign o_buf       = buf_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_shift_cnt = cnt_q;
    assign o_qh        = sr_q[WIDTH-1];

endmodule

// File: tb/tb_hc595_serial_rx.sv
// tb_hc595_serial_rx: directed, table-driven bench for hc595_serial_rx.
module tb_hc595_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin_data = 1'b0;
    logic       pin_dclk = 1'b0;
    logic       pin_rclk = 1'b0;
    logic [7:0] o_buf;
    logic       o_valid;
    logic       o_frame_err;
    logic [7:0] o_shift_cnt;
    logic       o_qh;

    hc595_serial_rx #(.WIDTH(8), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .SN74HC595_data(pin_data),
        .SN74HC595_data_clk(pin_dclk),
        .SN74HC595_refresh_clk(pin_rclk),
        .o_buf(o_buf), .o_valid(o_valid), .o_frame_err(o_frame_err),
        .o_shift_cnt(o_shift_cnt), .o_qh(o_qh)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Valid-strobe log, sampled on the falling edge.
    int         valid_cnt = 0;
    logic [7:0] buf_log [0:63];
    logic       err_log [0:63];

    always @(negedge clk) begin
        if (o_valid) begin
            buf_log[valid_cnt[5:0]] <= o_buf;
            err_log[valid_cnt[5:0]] <= o_frame_err;
            valid_cnt <= valid_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        @(negedge clk); pin_data = b;
        repeat (4) @(negedge clk);
        pin_dclk = 1'b1;
        repeat (8) @(negedge clk);
        pin_dclk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic latch_frame();
        @(negedge clk); pin_rclk = 1'b1;
        repeat (8) @(negedge clk);
        pin_rclk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic tied_edge(input logic b);
        @(negedge clk); pin_data = b;
        repeat (4) @(negedge clk);
        pin_dclk = 1'b1; pin_rclk = 1'b1;
        repeat (8) @(negedge clk);
        pin_dclk = 1'b0; pin_rclk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int          nbits;
        logic [15:0] bits;     // MSB-first, lowest nbits used
        logic [7:0]  exp_buf;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        int vc0;
        int n;
        logic [8:0] tied_bits;
        logic       b;

        // Frames applied back to back; each expected buffer follows from
        // the shift register left by the previous row.
        vecs[0] = '{nbits: 8,  bits: 16'h00B2,  exp_buf: 8'hB2, exp_err: 1'b0};
        vecs[1] = '{nbits: 5,  bits: 16'h0016,  exp_buf: 8'h56, exp_err: 1'b1};
        vecs[2] = '{nbits: 10, bits: 16'h02A5,  exp_buf: 8'hA5, exp_err: 1'b1};
        vecs[3] = '{nbits: 0,  bits: 16'h0000,  exp_buf: 8'hA5, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_buf",   {24'd0, o_buf},       32'h00);
        check("reset_valid", {31'd0, o_valid},     32'h0);
        check("reset_err",   {31'd0, o_frame_err}, 32'h0);
        check("reset_cnt",   {24'd0, o_shift_cnt}, 32'h0);
        check("reset_qh",    {31'd0, o_qh},        32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < vecs[r].nbits; i++) begin
                shift_bit(vecs[r].bits[vecs[r].nbits - 1 - i]);
                if (i >= 7) begin
                    check($sformatf("row%0d_qh_after_%0d", r, i + 1), {31'd0, o_qh},
                          {31'd0, vecs[r].bits[vecs[r].nbits - (i - 6)]});
                end
            end
            check($sformatf("row%0d_cnt_before_latch", r), {24'd0, o_shift_cnt}, 32'(vecs[r].nbits));
            vc0 = valid_cnt;
            latch_frame();
            check($sformatf("row%0d_valid_pulses", r), 32'(valid_cnt), 32'(vc0 + 1));
            check($sformatf("row%0d_buf", r), {24'd0, buf_log[vc0[5:0]]}, {24'd0, vecs[r].exp_buf});
            check($sformatf("row%0d_err", r), {31'd0, err_log[vc0[5:0]]}, {31'd0, vecs[r].exp_err});
            check($sformatf("row%0d_cnt_after_latch", r), {24'd0, o_shift_cnt}, 32'h0);
        end

        // Shift and storage clocks tied: storage lags shift by one stage.
        tied_bits = 9'b1_1000_0111;
        vc0 = valid_cnt;
        for (int i = 8; i >= 0; i--) begin
            b = tied_bits[i];
            tied_edge(b);
        end
        check("tied_valid_pulses", 32'(valid_cnt), 32'(vc0 + 9));
        check("tied_first_buf",    {24'd0, buf_log[vc0[5:0]]}, 32'hA5);
        check("tied_first_err",    {31'd0, err_log[vc0[5:0]]}, 32'h1);
        check("tied_last_buf",     {24'd0, buf_log[6'(vc0 + 8)]}, 32'hC3);
        check("tied_final_cnt",    {24'd0, o_shift_cnt}, 32'h1);

        // Edge latency: pin rise to counter update.
        @(negedge clk); pin_dclk = 1'b1;
        n = 0;
        while (o_shift_cnt != 8'd2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
`ifdef HC595_RX_GLITCH_FILTER_EN
        check("shift_latency", 32'(n), 32'd7);
`else
        check("shift_latency", 32'(n), 32'd4);
`endif
        @(negedge clk); pin_dclk = 1'b0;
        repeat (12) @(negedge clk);
        check("latency_cnt", {24'd0, o_shift_cnt}, 32'h2);

`ifdef HC595_RX_GLITCH_FILTER_EN
        @(negedge clk); pin_dclk = 1'b1;
        repeat (2) @(negedge clk); pin_dclk = 1'b0;
        repeat (14) @(negedge clk);
        check("glitch_2cyc_ignored", {24'd0, o_shift_cnt}, 32'h2);
        @(negedge clk); pin_dclk = 1'b1;
        repeat (4) @(negedge clk); pin_dclk = 1'b0;
        repeat (14) @(negedge clk);
        check("glitch_4cyc_shift", {24'd0, o_shift_cnt}, 32'h3);
`endif

        // Reset mid-frame discards the partial frame.
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        vc0 = valid_cnt;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_valid", 32'(valid_cnt), 32'(vc0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_buf", {24'd0, o_buf}, 32'h00);
        check("rst_mid_cnt", {24'd0, o_shift_cnt}, 32'h0);
        check("rst_mid_no_valid_after", 32'(valid_cnt), 32'(vc0));
        for (int i = 7; i >= 0; i--) begin
            b = (i >= 2 && i <= 5);   // 8'h3C
            shift_bit(b);
        end
        latch_frame();
        check("post_rst_valid", 32'(valid_cnt), 32'(vc0 + 1));
        check("post_rst_buf", {24'd0, buf_log[vc0[5:0]]}, 32'h3C);
        check("post_rst_err", {31'd0, err_log[vc0[5:0]]}, 32'h0);
        check("post_rst_cnt", {24'd0, o_shift_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
